// File: rtl/alu_result_display_if.sv
// Bus between the ALU bench and its read-out: capture request, ALU result and flags
// going in, status, flag LEDs and four active-low 7-segment digits coming out.
interface alu_result_display_if #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 5
);
  logic              load;
  logic [DATA_W-1:0] value;
  logic [FLAG_W-1:0] flags_in;
  logic              dec_mode;
  logic              busy;
  logic              done;
  logic              over_range;
  logic [FLAG_W-1:0] flags_led;
  logic [6:0]        hex0;
  logic [6:0]        hex1;
  logic [6:0]        hex2;
  logic [6:0]        hex3;

  modport master (
    output load, value, flags_in, dec_mode,
    input  busy, done, over_range, flags_led, hex0, hex1, hex2, hex3
  );

  modport slave (
    input  load, value, flags_in, dec_mode,
    output busy, done, over_range, flags_led, hex0, hex1, hex2, hex3
  );
endinterface

// File: rtl/alu_result_display.sv
// ALU result read-out: captures result/flags on load and shows them on four
// active-low 7-segment digits, either as hex nibbles or as the low four decimal
// digits produced by a sequential double-dabble conversion.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for load; display holds last values
//   S_SHIFT  | one double-dabble iteration per cycle, DATA_W cycles total
//   S_UPDATE | display, flags_led and over_range are written on this edge
module alu_result_display #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_result_display_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

  state_t            state_q, state_d;
  // shreg_q doubles as the captured value for hex mode, since it only shifts in decimal mode
  logic [DATA_W-1:0] shreg_q;
  logic [FLAG_W-1:0] flags_q;
  logic              dec_q;
  logic [19:0]       bcd_q;
  logic [19:0]       bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       val_ext;
  logic              capture;
  logic              last_shift;
  logic [6:0]        hex0_q, hex1_q, hex2_q, hex3_q;
  logic [FLAG_W-1:0] flags_led_q;
  logic              over_range_q;
  logic              done_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h18;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h27;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign capture    = (state_q == S_IDLE) && bus.load;
  assign last_shift = (cnt_q == CNT_LAST);
  assign val_ext    = 16'(shreg_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.load) state_d = bus.dec_mode ? S_SHIFT : S_UPDATE;
      S_SHIFT:  if (last_shift) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Add-3 correction of every BCD digit ahead of the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Capture and double-dabble shift datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      flags_q <= '0;
      dec_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (capture) begin
      shreg_q <= bus.value;
      flags_q <= bus.flags_in;
      dec_q   <= bus.dec_mode;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == S_SHIFT) begin
      {bcd_q, shreg_q} <= {bcd_adj, shreg_q} << 1;
      cnt_q            <= cnt_q + 1'b1;
    end
  end

  // Display, flag LEDs, over-range and done pulse, written on the UPDATE edge
  always_ff @(posedge clk) begin
    if (reset) begin
      hex0_q       <= 7'h40;
      hex1_q       <= 7'h40;
      hex2_q       <= 7'h40;
      hex3_q       <= 7'h40;
      flags_led_q  <= '0;
      over_range_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_UPDATE) begin
        done_q      <= 1'b1;
        flags_led_q <= flags_q;
        if (dec_q) begin
          hex0_q       <= seg7(bcd_q[3:0]);
          hex1_q       <= seg7(bcd_q[7:4]);
          hex2_q       <= seg7(bcd_q[11:8]);
          hex3_q       <= seg7(bcd_q[15:12]);
          over_range_q <= (bcd_q[19:16] != 4'd0);
        end else begin
          hex0_q       <= seg7(val_ext[3:0]);
          hex1_q       <= seg7(val_ext[7:4]);
          hex2_q       <= seg7(val_ext[11:8]);
          hex3_q       <= seg7(val_ext[15:12]);
          over_range_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.over_range = over_range_q;
  assign bus.flags_led  = flags_led_q;
  assign bus.hex0       = hex0_q;
  assign bus.hex1       = hex1_q;
  assign bus.hex2       = hex2_q;
  assign bus.hex3       = hex3_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: reset state, hex and decimal read-out,
// decimal boundaries, loads while busy, back-to-back load in the done cycle and
// reset during a conversion.
module tb_alu_result_display;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_result_display_if #(.DATA_W(16), .FLAG_W(5)) bus ();

  alu_result_display #(.DATA_W(16), .FLAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one load pulse; returns at the falling edge after the capturing edge.
  task automatic pulse_load(input logic [15:0] v, input logic [4:0] f, input logic d);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.value    = v;
    bus.flags_in = f;
    bus.dec_mode = d;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (bus.hex0 !== 7'h40) begin bad++; $display("FAIL reset_hex0 got %h want 40", bus.hex0); end
    total++; if (bus.hex1 !== 7'h40) begin bad++; $display("FAIL reset_hex1 got %h want 40", bus.hex1); end
    total++; if (bus.hex2 !== 7'h40) begin bad++; $display("FAIL reset_hex2 got %h want 40", bus.hex2); end
    total++; if (bus.hex3 !== 7'h40) begin bad++; $display("FAIL reset_hex3 got %h want 40", bus.hex3); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    total++; if (bus.flags_led !== 5'b0) begin bad++; $display("FAIL reset_flags got %b want 00000", bus.flags_led); end
    total++; if (bus.over_range !== 1'b0) begin bad++; $display("FAIL reset_ovr got %b want 0", bus.over_range); end
  endtask

  task automatic test_hex();
    pulse_load(16'hBEEF, 5'b10101, 1'b0);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL hex_busy_update got %b want 1", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hex_done_early got %b want 0", bus.done); end
    @(negedge clk);
    total++; if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !== {7'h03, 7'h06, 7'h06, 7'h0E}) begin
      bad++; $display("FAIL hex_digits got %h %h %h %h want 03 06 06 0e", bus.hex3, bus.hex2, bus.hex1, bus.hex0);
    end
    total++; if (bus.flags_led !== 5'b10101) begin bad++; $display("FAIL hex_flags got %b want 10101", bus.flags_led); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL hex_done got %b want 1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hex_busy_after got %b want 0", bus.busy); end
    total++; if (bus.over_range !== 1'b0) begin bad++; $display("FAIL hex_ovr got %b want 0", bus.over_range); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hex_done_width got %b want 0", bus.done); end
    total++; if (bus.hex3 !== 7'h03) begin bad++; $display("FAIL hex_hold got %h want 03", bus.hex3); end
  endtask

  task automatic test_decimal(input logic [15:0] v, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0, input logic ovr, input string name);
    int n;
    pulse_load(v, 5'b00011, 1'b1);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++; if (n != 17) begin bad++; $display("FAIL %s busy_cycles got %0d want 17", name, n); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL %s done got %b want 1", name, bus.done); end
    total++; if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !== {e3, e2, e1, e0}) begin
      bad++; $display("FAIL %s digits got %h %h %h %h want %h %h %h %h", name,
                      bus.hex3, bus.hex2, bus.hex1, bus.hex0, e3, e2, e1, e0);
    end
    total++; if (bus.over_range !== ovr) begin bad++; $display("FAIL %s ovr got %b want %b", name, bus.over_range, ovr); end
    @(negedge clk);
  endtask

  task automatic test_load_while_busy();
    int dones;
    dones = 0;
    pulse_load(16'd100, 5'b00001, 1'b1);
    for (int n = 0; n < 30; n++) begin
      bus.load     = (n == 3 || n == 10);
      bus.value    = 16'h0001;
      bus.dec_mode = 1'b0;
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    bus.load = 1'b0;
    total++; if (dones != 1) begin bad++; $display("FAIL busy_load done_count got %0d want 1", dones); end
    total++; if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !== {7'h40, 7'h79, 7'h40, 7'h40}) begin
      bad++; $display("FAIL busy_load digits got %h %h %h %h want 40 79 40 40", bus.hex3, bus.hex2, bus.hex1, bus.hex0);
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_load busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    pulse_load(16'h1234, 5'b00001, 1'b0);
    @(negedge clk);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b first_done got %b want 1", bus.done); end
    bus.load     = 1'b1;
    bus.value    = 16'h0005;
    bus.flags_in = 5'b11111;
    bus.dec_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b accepted got busy=%b want 1", bus.busy); end
    @(negedge clk);
    total++; if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !== {7'h40, 7'h40, 7'h40, 7'h12}) begin
      bad++; $display("FAIL b2b digits got %h %h %h %h want 40 40 40 12", bus.hex3, bus.hex2, bus.hex1, bus.hex0);
    end
    total++; if (bus.flags_led !== 5'b11111) begin bad++; $display("FAIL b2b flags got %b want 11111", bus.flags_led); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b second_done got %b want 1", bus.done); end
  endtask

  task automatic test_reset_abort();
    int dones;
    pulse_load(16'd4321, 5'b01010, 1'b1);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got %b want 0", bus.done); end
    total++; if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !== {4{7'h40}}) begin
      bad++; $display("FAIL abort_digits got %h %h %h %h want 40 40 40 40", bus.hex3, bus.hex2, bus.hex1, bus.hex0);
    end
    total++; if (bus.flags_led !== 5'b0) begin bad++; $display("FAIL abort_flags got %b want 00000", bus.flags_led); end
    reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_late_done got %0d want 0", dones); end
    pulse_load(16'h00A5, 5'b00011, 1'b0);
    @(negedge clk);
    total++; if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !== {7'h40, 7'h40, 7'h08, 7'h12}) begin
      bad++; $display("FAIL abort_hex_digits got %h %h %h %h want 40 40 08 12", bus.hex3, bus.hex2, bus.hex1, bus.hex0);
    end
    total++; if (bus.flags_led !== 5'b00011) begin bad++; $display("FAIL abort_hex_flags got %b want 00011", bus.flags_led); end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.flags_in = '0;
    bus.dec_mode = 1'b0;

    test_reset();
    test_hex();
    test_decimal(16'd12345, 7'h24, 7'h30, 7'h19, 7'h12, 1'b1, "dec_12345");
    test_decimal(16'd9999,  7'h18, 7'h18, 7'h18, 7'h18, 1'b0, "dec_9999");
    test_decimal(16'd0,     7'h40, 7'h40, 7'h40, 7'h40, 1'b0, "dec_0");
    test_decimal(16'd65535, 7'h12, 7'h12, 7'h30, 7'h12, 1'b1, "dec_65535");
    test_load_while_busy();
    test_back_to_back();
    test_reset_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
